// File: rtl/apb_pkg.sv
// Shared APB initiator types: FSM state encoding, data width, and the request/response
// records that APB initiators pass around.
package apb_pkg;

    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_MAX_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    // Addresses are carried at full width; each initiator uses its own low slice.
    typedef struct packed {
        logic [APB_MAX_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0]     wdata;
        logic                          write;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_resp_t;

endpackage

// File: rtl/apb_master_req.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS on the bus,
// bounded wait for PREADY, registered response held until consumed.
module apb_master_req
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    input  logic                      req_write_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      resp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // A disabled timeout still needs a one-bit counter to keep the datapath legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_mst_state_e            state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [APB_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic [APB_DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic                      pwrite_reg, pwrite_next;
    apb_resp_t                 resp_reg, resp_next;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
            pwrite_reg <= 1'b0;
            resp_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            paddr_reg  <= paddr_next;
            pwdata_reg <= pwdata_next;
            pwrite_reg <= pwrite_next;
            resp_reg   <= resp_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        paddr_next  = paddr_reg;
        pwdata_next = pwdata_reg;
        pwrite_next = pwrite_reg;
        resp_next   = resp_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_next  = req_addr_i;
                    pwdata_next = req_wdata_i;
                    pwrite_next = req_write_i;
                    cnt_next    = '0;
                    state_next  = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    resp_next.err     = PSLVERR;
                    resp_next.timeout = 1'b0;
                    resp_next.rdata   = pwrite_reg ? '0 : PRDATA;
                    state_next        = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
                    // Counter reaches TIMEOUT-1 on the TIMEOUT-th waited ACCESS cycle.
                    resp_next.err     = 1'b1;
                    resp_next.timeout = 1'b1;
                    resp_next.rdata   = '0;
                    state_next        = RESP;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes decode straight from the state register, so reset drops them at once.
    assign req_ready_o    = (state_reg == IDLE);
    assign PSEL           = (state_reg == SETUP) || (state_reg == ACCESS);
    assign PENABLE        = (state_reg == ACCESS);
    assign resp_valid_o   = (state_reg == RESP);
    assign PADDR          = paddr_reg;
    assign PWDATA         = pwdata_reg;
    assign PWRITE         = pwrite_reg;
    assign resp_rdata_o   = resp_reg.rdata;
    assign resp_err_o     = resp_reg.err;
    assign resp_timeout_o = resp_reg.timeout;

endmodule

// File: tb/tb_apb_master_req.sv
// Bench for apb_master_req: table of APB transactions with a response scoreboard,
// plus hand-written backpressure and mid-transfer reset sequences.
module tb_apb_master_req;
    import apb_pkg::*;

    localparam int AW = 12;
    localparam int TO = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic          req_write_i = 1'b0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b1;
    logic [31:0]   resp_rdata_o;
    logic          resp_err_o;
    logic          resp_timeout_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_master_req #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .resp_timeout_o(resp_timeout_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          write;
        int            waits;      // PREADY-low ACCESS cycles before ready
        logic          slverr;
        logic [31:0]   prdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_len;    // ACCESS cycles expected
    } vec_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    apb_resp_t sb_q[$];
    vec_t      vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Scoreboard side: every response handshake pops one expected record.
    always @(negedge HCLK) begin : mon
        apb_resp_t e;
        if (HRESETn && resp_valid_o && resp_ready_i) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata=0x%08h err=%0b to=%0b expected none",
                         resp_rdata_o, resp_err_o, resp_timeout_o);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] resp rdata=0x%08h err=%0b to=%0b", resp_rdata_o, resp_err_o, resp_timeout_o);
                check("resp_rdata", resp_rdata_o, e.rdata);
                check("resp_err", 32'(resp_err_o), 32'(e.err));
                check("resp_timeout", 32'(resp_timeout_o), 32'(e.timeout));
            end
        end
    end

    // Called 1 time unit after a rising edge; returns in SETUP.
    task automatic issue(input vec_t v, input bit push);
        apb_resp_t e;
        req_valid_i = 1'b1;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        req_write_i = v.write;
        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        @(posedge HCLK); #1;
        req_valid_i = 1'b0;
        if (push) begin
            e.rdata = v.exp_rdata; e.err = v.exp_err; e.timeout = v.exp_to;
            sb_q.push_back(e);
        end
        check("setup_psel", 32'(PSEL), 32'd1);
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("setup_paddr", 32'(PADDR), 32'(v.addr));
        // Bus inputs outside ACCESS must be ignored.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
    endtask

    task automatic access(input vec_t v);
        int acc = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge HCLK); #1;
            if (!(PSEL && PENABLE)) break;
            acc++;
            check("acc_paddr", 32'(PADDR), 32'(v.addr));
            check("acc_pwrite", 32'(PWRITE), 32'(v.write));
            check("acc_pwdata", PWDATA, v.wdata);
            PREADY  = ((acc - 1) == v.waits);
            PSLVERR = v.slverr;
            PRDATA  = v.prdata;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        check("access_len", 32'(acc), 32'(v.exp_len));
        check("resp_valid", 32'(resp_valid_o), 32'd1);
        check("resp_psel", 32'(PSEL), 32'd0);
    endtask

    task automatic complete();
        @(posedge HCLK); #1;
        check("post_resp_valid", 32'(resp_valid_o), 32'd0);
        check("post_req_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        vec_t bp1, bp2, rv;
        vecs[0] = '{12'h000, 32'h0000_0021, 1'b1, 0,   1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1};
        vecs[1] = '{12'h004, 32'h0,         1'b0, 3,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
        vecs[2] = '{12'h008, 32'h0,         1'b0, 0,   1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1};
        vecs[3] = '{12'h00C, 32'h0,         1'b0, 255, 1'b0, 32'h7777_7777, 32'h0,         1'b1, 1'b1, TO};
        vecs[4] = '{12'hFFC, 32'hA5A5_A5A5, 1'b1, 2,   1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 3};
        vecs[5] = '{12'hFFF, 32'h0,         1'b0, 7,   1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 8};
        vecs[6] = '{12'h123, 32'h5A5A_0001, 1'b1, 0,   1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1};
        vecs[7] = '{12'h010, 32'hFFFF_FFFF, 1'b1, 255, 1'b1, 32'h0,         32'h0,         1'b1, 1'b1, TO};

        repeat (3) @(posedge HCLK);
        #1;
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_rdata", resp_rdata_o, 32'd0);
        check("rst_resp_err", 32'(resp_err_o), 32'd0);
        check("rst_resp_to", 32'(resp_timeout_o), 32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 8; i++) begin
            $display("[TB] txn %0d addr=0x%03h write=%0b waits=%0d", i, vecs[i].addr, vecs[i].write, vecs[i].waits);
            issue(vecs[i], 1'b1);
            access(vecs[i]);
            complete();
        end

        // Response backpressure with a new request waiting.
        bp1 = '{12'h020, 32'h0, 1'b0, 1, 1'b0, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 1'b0, 2};
        bp2 = '{12'h024, 32'h0, 1'b0, 0, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 1};
        $display("[TB] txn backpressure addr=0x%03h", bp1.addr);
        resp_ready_i = 1'b0;
        issue(bp1, 1'b1);
        access(bp1);
        req_valid_i = 1'b1; req_addr_i = bp2.addr; req_write_i = 1'b0; req_wdata_i = bp2.wdata;
        for (int k = 0; k < 5; k++) begin
            @(posedge HCLK); #1;
            check("bp_resp_valid", 32'(resp_valid_o), 32'd1);
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
            check("bp_psel", 32'(PSEL), 32'd0);
            check("bp_rdata", resp_rdata_o, 32'h55AA_55AA);
        end
        resp_ready_i = 1'b1;
        @(posedge HCLK); #1;
        check("bp_idle_ready", 32'(req_ready_o), 32'd1);
        check("bp_idle_valid", 32'(resp_valid_o), 32'd0);
        $display("[TB] txn queued addr=0x%03h", bp2.addr);
        sb_q.push_back('{rdata: bp2.exp_rdata, err: 1'b0, timeout: 1'b0});
        @(posedge HCLK); #1;
        req_valid_i = 1'b0;
        check("bp_next_psel", 32'(PSEL), 32'd1);
        check("bp_next_penable", 32'(PENABLE), 32'd0);
        check("bp_next_paddr", 32'(PADDR), 32'(bp2.addr));
        access(bp2);
        complete();

        // Reset during an ACCESS wait state: no response may appear afterwards.
        rv = '{12'h030, 32'h0, 1'b0, 255, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, TO};
        $display("[TB] txn reset-abort addr=0x%03h", rv.addr);
        issue(rv, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge HCLK); #1;
            PREADY = 1'b0; PSLVERR = 1'b0;
        end
        check("pre_rst_penable", 32'(PENABLE), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("arst_psel", 32'(PSEL), 32'd0);
        check("arst_penable", 32'(PENABLE), 32'd0);
        check("arst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("arst_paddr", 32'(PADDR), 32'd0);
        @(negedge HCLK); HRESETn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge HCLK); #1;
            check("after_rst_ready", 32'(req_ready_o), 32'd1);
            check("after_rst_valid", 32'(resp_valid_o), 32'd0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
